ball_motion_ctrl: RTL and testbench

Frame-synchronous motion controller for the bouncing-ball sprite. It sequences one position update per scheduled frame, computes a clamped step with edge bounce per axis, and commits the new centre atomically so the pixel datapath never sees a half-updated position. Its inputs come from the sync generator's frame-start pulse and the user-input pins. Its outputs drive the sprite renderer's `center_x`/`center_y`.

---
 rtl/ball_pkg.sv | 28 ++
 rtl/ball_motion_ctrl_axis_step.sv | 56 +++++
 rtl/ball_motion_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// ============================================================================
// ball_pkg : shared constants and FSM encoding for the ball motion controller
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package ball_pkg;

    localparam int C_POS_W     = 10;
    localparam int C_SPEED_W   = 3;
    localparam int C_STATE_W   = 2;

    localparam int C_DEF_H_RES  = 640;
    localparam int C_DEF_V_RES  = 480;
    localparam int C_DEF_RADIUS = 100;
    localparam int C_DEF_INIT_X = 320;
    localparam int C_DEF_INIT_Y = 240;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC_X = 2'd1,
        ST_CALC_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ball_motion_ctrl_axis_step.sv
// ============================================================================
// ball_axis_step : one-axis clamped step with edge bounce (combinational)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module ball_axis_step
    import ball_pkg::*;
(
    input  logic [C_POS_W-1:0]   i_p,
    input  logic                 i_dir,
    input  logic [C_SPEED_W-1:0] i_speed,
    input  logic [C_POS_W-1:0]   i_min,
    input  logic [C_POS_W-1:0]   i_max,
    output logic [C_POS_W-1:0]   o_n,
    output logic                 o_dir,
    output logic                 o_flip
);

    logic [C_POS_W:0] w_speed_ext;
    logic [C_POS_W:0] w_sum;
    logic [C_POS_W:0] w_floor;

    // 11-bit sums so p+speed near the top of the range cannot wrap
    assign w_speed_ext = {{(C_POS_W+1-C_SPEED_W){1'b0}}, i_speed};
    assign w_sum       = {1'b0, i_p} + w_speed_ext;
    assign w_floor     = {1'b0, i_min} + w_speed_ext;

    always_comb begin
        o_n    = i_p;
        o_dir  = i_dir;
        o_flip = 1'b0;
        if (i_speed != '0) begin
            if (i_dir) begin
                if (w_sum >= {1'b0, i_max}) begin
                    o_n    = i_max;
                    o_dir  = 1'b0;
                    o_flip = 1'b1;
                end else begin
                    o_n = w_sum[C_POS_W-1:0];
                end
            end else begin
                if ({1'b0, i_p} <= w_floor) begin
                    o_n    = i_min;
                    o_dir  = 1'b1;
                    o_flip = 1'b1;
                end else begin
                    o_n = i_p - w_speed_ext[C_POS_W-1:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
// ============================================================================
// ball_motion_ctrl : frame-synchronous sprite motion with shadowed commit
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int H_RES  = C_DEF_H_RES,
    parameter int V_RES  = C_DEF_V_RES,
    parameter int RADIUS = C_DEF_RADIUS,
    parameter int INIT_X = C_DEF_INIT_X,
    parameter int INIT_Y = C_DEF_INIT_Y,
    parameter int DIV_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 run,
    input  logic [C_SPEED_W-1:0] speed,
    input  logic [DIV_W-1:0]     frame_div,
    output logic [C_POS_W-1:0]   ball_x,
    output logic [C_POS_W-1:0]   ball_y,
    output logic                 dir_x,
    output logic                 dir_y,
    output logic [1:0]           bounce,
    output logic                 busy,
    output logic [7:0]           step_count
);

    localparam logic [C_POS_W-1:0] C_XMIN  = C_POS_W'(RADIUS);
    localparam logic [C_POS_W-1:0] C_XMAX  = C_POS_W'(H_RES - 1 - RADIUS);
    localparam logic [C_POS_W-1:0] C_YMIN  = C_POS_W'(RADIUS);
    localparam logic [C_POS_W-1:0] C_YMAX  = C_POS_W'(V_RES - 1 - RADIUS);
    localparam logic [C_POS_W-1:0] C_INITX = C_POS_W'(INIT_X);
    localparam logic [C_POS_W-1:0] C_INITY = C_POS_W'(INIT_Y);
    localparam logic [DIV_W-1:0]   C_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [C_POS_W-1:0]   shadow_x_q, shadow_x_d;
    logic [C_POS_W-1:0]   shadow_y_q, shadow_y_d;
    logic                 shadow_dx_q, shadow_dx_d;
    logic                 shadow_dy_q, shadow_dy_d;
    logic [1:0]           flip_q, flip_d;
    logic [C_POS_W-1:0]   ball_x_q, ball_x_d;
    logic [C_POS_W-1:0]   ball_y_q, ball_y_d;
    logic                 dir_x_q, dir_x_d;
    logic                 dir_y_q, dir_y_d;
    logic [1:0]           bounce_q, bounce_d;
    logic [7:0]           step_cnt_q, step_cnt_d;

    logic                 w_accept;
    logic                 w_launch;
    logic                 w_busy;
    logic                 w_calc_y;
    logic [C_POS_W-1:0]   w_p;
    logic                 w_dir;
    logic [C_POS_W-1:0]   w_min;
    logic [C_POS_W-1:0]   w_max;
    logic [C_POS_W-1:0]   w_n;
    logic                 w_new_dir;
    logic                 w_flip;

    // Frames arriving while busy never reach the divider
    assign w_accept = (state_q == ST_IDLE) && frame_start;
    assign w_launch = w_accept && run && (div_cnt_q >= frame_div);

    // A single step unit is shared; the FSM state selects which axis feeds it
    assign w_p   = w_calc_y ? ball_y_q : ball_x_q;
    assign w_dir = w_calc_y ? dir_y_q  : dir_x_q;
    assign w_min = w_calc_y ? C_YMIN   : C_XMIN;
    assign w_max = w_calc_y ? C_YMAX   : C_XMAX;

    ball_axis_step u_axis_step (
        .i_p     (w_p),
        .i_dir   (w_dir),
        .i_speed (speed),
        .i_min   (w_min),
        .i_max   (w_max),
        .o_n     (w_n),
        .o_dir   (w_new_dir),
        .o_flip  (w_flip)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_launch) state_d = ST_CALC_X;
            ST_CALC_X: state_d = ST_CALC_Y;
            ST_CALC_Y: state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (state_q != ST_IDLE);
        w_calc_y = (state_q == ST_CALC_Y);
    end

    always_comb begin
        div_cnt_d   = div_cnt_q;
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        shadow_dx_d = shadow_dx_q;
        shadow_dy_d = shadow_dy_q;
        flip_d      = flip_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        bounce_d    = 2'b00;
        step_cnt_d  = step_cnt_q;

        if (w_accept) begin
            if (!run) begin
                div_cnt_d = '0;
            end else if (w_launch) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + C_DIV_ONE;
            end
        end

        case (state_q)
            ST_CALC_X: begin
                shadow_x_d  = w_n;
                shadow_dx_d = w_new_dir;
                flip_d[0]   = w_flip;
            end
            ST_CALC_Y: begin
                shadow_y_d  = w_n;
                shadow_dy_d = w_new_dir;
                flip_d[1]   = w_flip;
            end
            ST_COMMIT: begin
                ball_x_d   = shadow_x_q;
                ball_y_d   = shadow_y_q;
                dir_x_d    = shadow_dx_q;
                dir_y_d    = shadow_dy_q;
                bounce_d   = flip_q;
                step_cnt_d = step_cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q   <= '0;
            shadow_x_q  <= C_INITX;
            shadow_y_q  <= C_INITY;
            shadow_dx_q <= 1'b1;
            shadow_dy_q <= 1'b1;
            flip_q      <= 2'b00;
            ball_x_q    <= C_INITX;
            ball_y_q    <= C_INITY;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            bounce_q    <= 2'b00;
            step_cnt_q  <= 8'd0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            shadow_dx_q <= shadow_dx_d;
            shadow_dy_q <= shadow_dy_d;
            flip_q      <= flip_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            bounce_q    <= bounce_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign dir_x      = dir_x_q;
    assign dir_y      = dir_y_q;
    assign bounce     = bounce_q;
    assign busy       = w_busy;
    assign step_count = step_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_ctrl.sv
// ============================================================================
// tb_ball_motion_ctrl : directed + randomized check against a behavioural model
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module tb_ball_motion_ctrl;

    localparam int XMIN = 100;
    localparam int XMAX = 539;
    localparam int YMIN = 100;
    localparam int YMAX = 379;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       run = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [3:0] frame_div = 4'd0;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, busy;
    logic [1:0] bounce;
    logic [7:0] step_count;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    int mx, my, mdx, mdy, mcnt, msteps, mbnc;

    always #5 clk = ~clk;

    ball_motion_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .run         (run),
        .speed       (speed),
        .frame_div   (frame_div),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .bounce      (bounce),
        .busy        (busy),
        .step_count  (step_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic axis_model(input int p, input int d, input int s, input int mn, input int mxl,
                              output int np, output int nd, output int fl);
        np = p; nd = d; fl = 0;
        if (s != 0) begin
            if (d == 1) begin
                if (p + s >= mxl) begin np = mxl; nd = 0; fl = 1; end
                else np = p + s;
            end else begin
                if (p <= mn + s) begin np = mn; nd = 1; fl = 1; end
                else np = p - s;
            end
        end
    endtask

    task automatic model_reset();
        mx = 320; my = 240; mdx = 1; mdy = 1; mcnt = 0; msteps = 0; mbnc = 0;
    endtask

    // returns 1 if this accepted frame launches an update
    task automatic model_divider(output int launch);
        launch = 0;
        if (run) begin
            if (mcnt >= int'(frame_div)) begin mcnt = 0; launch = 1; end
            else mcnt++;
        end else begin
            mcnt = 0;
        end
    endtask

    task automatic model_update(input int sx, input int sy);
        int nx, ndx, fx, ny, ndy, fy;
        axis_model(mx, mdx, sx, XMIN, XMAX, nx, ndx, fx);
        axis_model(my, mdy, sy, YMIN, YMAX, ny, ndy, fy);
        mx = nx; mdx = ndx; my = ny; mdy = ndy;
        mbnc = fy * 2 + fx;
        msteps = (msteps + 1) % 256;
    endtask

    task automatic chk_state(input string pfx, input int exp_bnc);
        chk({pfx, ".ball_x"}, 32'(ball_x), mx);
        chk({pfx, ".ball_y"}, 32'(ball_y), my);
        chk({pfx, ".dir_x"}, 32'(dir_x), mdx);
        chk({pfx, ".dir_y"}, 32'(dir_y), mdy);
        chk({pfx, ".bounce"}, 32'(bounce), exp_bnc);
        chk({pfx, ".step_count"}, 32'(step_count), msteps);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        #1;
        model_reset();
        chk_state("reset", 0);
        chk("reset.busy", 32'(busy), 0);
        @(negedge clk) reset = 1'b0;
    endtask

    // one frame_start pulse from IDLE; checks the full 3-cycle update timeline
    task automatic frame(input string pfx);
        int launch;
        int px, py;
        model_divider(launch);
        px = mx; py = my;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        if (launch == 1) begin
            chk({pfx, ".busy_calc_x"}, 32'(busy), 1);
            @(negedge clk);
            chk({pfx, ".x_held"}, 32'(ball_x), px);
            @(negedge clk);
            chk({pfx, ".busy_commit"}, 32'(busy), 1);
            chk({pfx, ".y_held"}, 32'(ball_y), py);
            model_update(int'(speed), int'(speed));
            @(negedge clk);
            chk_state(pfx, mbnc);
            chk({pfx, ".busy_done"}, 32'(busy), 0);
            @(negedge clk);
            chk({pfx, ".bounce_clr"}, 32'(bounce), 0);
        end else begin
            chk({pfx, ".busy_idle"}, 32'(busy), 0);
            repeat (3) @(negedge clk);
            chk_state(pfx, 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        do_reset();

        // single step
        run = 1'b1; speed = 3'd2; frame_div = 4'd0;
        frame("single");
        chk("single.x322", 32'(ball_x), 322);
        chk("single.y242", 32'(ball_y), 242);

        // bottom and right bounces
        do_reset();
        run = 1'b1; speed = 3'd7; frame_div = 4'd0;
        for (int i = 1; i <= 33; i++) begin
            frame("bounce_seq");
            if (i == 20) begin
                chk("bottom.y", 32'(ball_y), 379);
                chk("bottom.dir_y", 32'(dir_y), 0);
                chk("bottom.bounce", 32'(bounce_seen_last()), 2);
            end
            if (i == 32) begin
                chk("right.x", 32'(ball_x), 539);
                chk("right.dir_x", 32'(dir_x), 0);
                chk("right.bounce", 32'(bounce_seen_last()), 1);
            end
            if (i == 33) chk("right.x_after", 32'(ball_x), 532);
        end

        // divider
        do_reset();
        run = 1'b1; speed = 3'd3; frame_div = 4'd2;
        for (int i = 0; i < 6; i++) frame("divider");
        chk("divider.steps", 32'(step_count), 2);

        // frame_start held into the busy window is ignored
        do_reset();
        run = 1'b1; speed = 3'd4; frame_div = 4'd0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk);
        @(negedge clk) frame_start = 1'b0;
        model_update(4, 4);
        repeat (2) @(negedge clk);
        chk_state("ignored", mbnc);
        repeat (6) @(negedge clk);
        chk("ignored.one_commit", 32'(step_count), 1);
        chk("ignored.idle", 32'(busy), 0);

        // speed 0 freezes position but still counts a step
        speed = 3'd0;
        frame("speed0");

        // per-axis speed sampling when speed changes mid-update
        speed = 3'd3;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk) speed = 3'd6;
        model_update(3, 6);
        repeat (2) @(negedge clk);
        chk_state("midspeed", mbnc);

        // reset during CALC_Y discards the update
        run = 1'b1; speed = 3'd5; frame_div = 4'd0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk) reset = 1'b1;
        #1;
        model_reset();
        chk_state("midreset", 0);
        chk("midreset.busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midreset.no_pulse", 32'(bounce), 0);
            chk("midreset.idle", 32'(busy), 0);
        end
        frame("post_reset");

        // randomized frames
        for (int i = 0; i < 60; i++) begin
            speed     = 3'($urandom_range(0, 7));
            frame_div = 4'($urandom_range(0, 3));
            run       = ($urandom_range(0, 9) != 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            frame("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // bounce flags the model predicted for the most recent commit
    function automatic int bounce_seen_last();
        return mbnc;
    endfunction

endmodule

`default_nettype wire
